// File: rtl/ctrl_seq_if.sv
// Sequencer bus: opcode and run/step controls in, per-T-state control strobes and state out.
// master drives opcode/run/step; slave is the sequencer.
interface ctrl_seq_if;
  logic [3:0] ins;
  logic       run;
  logic       step;
  logic       pc_inc;
  logic       pc_out;
  logic       pc_load;
  logic       mar_in;
  logic       ram_out;
  logic       ir_in;
  logic       ir_out;
  logic       acc_in;
  logic       acc_out;
  logic       breg_in;
  logic       alu_sub;
  logic       alu_out;
  logic       outreg_in;
  logic       halted;
  logic [2:0] tstate;

  modport master (
    output ins, run, step,
    input  pc_inc, pc_out, pc_load, mar_in, ram_out, ir_in, ir_out,
    input  acc_in, acc_out, breg_in, alu_sub, alu_out, outreg_in, halted, tstate
  );

  modport slave (
    input  ins, run, step,
    output pc_inc, pc_out, pc_load, mar_in, ram_out, ir_in, ir_out,
    output acc_in, acc_out, breg_in, alu_sub, alu_out, outreg_in, halted, tstate
  );
endinterface

// File: rtl/ctrl_seq.sv
// T-state control sequencer for the 8-bit accumulator CPU: fixed T1-T3 fetch, opcode-driven T4-T6 execute, HALT.
// Strobes are combinational from state/opcode and gated by the advance enable, so a held state never repeats a load.
module ctrl_seq #(
  parameter bit         SHORT_CYCLE = 1'b0,
  parameter logic [3:0] OP_LDA      = 4'h0,
  parameter logic [3:0] OP_ADD      = 4'h1,
  parameter logic [3:0] OP_SUB      = 4'h2,
  parameter logic [3:0] OP_JMP      = 4'h3,
  parameter logic [3:0] OP_OUT      = 4'hE,
  parameter logic [3:0] OP_HLT      = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  ctrl_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    T6   = 3'd5,
    HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic pc_load;
    logic mar_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic acc_in;
    logic acc_out;
    logic breg_in;
    logic alu_sub;
    logic alu_out;
    logic outreg_in;
  } ctrl_t;

  state_t r_state;
  state_t w_next;
  logic   r_step_q;
  logic   w_en;
  logic   w_arith;
  ctrl_t  w_ctrl;
  ctrl_t  w_gated;

  assign w_en    = bus.run | (bus.step & ~r_step_q);
  assign w_arith = (bus.ins == OP_ADD) || (bus.ins == OP_SUB);

  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    case (r_state)
      T1: begin
        w_ctrl.pc_out = 1'b1;
        w_ctrl.mar_in = 1'b1;
        w_next        = T2;
      end
      T2: begin
        w_ctrl.pc_inc = 1'b1;
        w_next        = T3;
      end
      T3: begin
        w_ctrl.ram_out = 1'b1;
        w_ctrl.ir_in   = 1'b1;
        w_next         = T4;
      end
      T4: begin
        // Only memory-operand instructions need T5 when short-cycling.
        w_next = SHORT_CYCLE ? T1 : T5;
        if (bus.ins == OP_LDA || w_arith) begin
          w_ctrl.ir_out = 1'b1;
          w_ctrl.mar_in = 1'b1;
          w_next        = T5;
        end else if (bus.ins == OP_JMP) begin
          w_ctrl.ir_out  = 1'b1;
          w_ctrl.pc_load = 1'b1;
        end else if (bus.ins == OP_OUT) begin
          w_ctrl.acc_out   = 1'b1;
          w_ctrl.outreg_in = 1'b1;
        end else if (bus.ins == OP_HLT) begin
          w_next = HALT;
        end
      end
      T5: begin
        w_next = (SHORT_CYCLE && bus.ins == OP_LDA) ? T1 : T6;
        if (bus.ins == OP_LDA) begin
          w_ctrl.ram_out = 1'b1;
          w_ctrl.acc_in  = 1'b1;
        end else if (w_arith) begin
          w_ctrl.ram_out = 1'b1;
          w_ctrl.breg_in = 1'b1;
        end
      end
      T6: begin
        w_next = T1;
        if (w_arith) begin
          w_ctrl.alu_out = 1'b1;
          w_ctrl.acc_in  = 1'b1;
          w_ctrl.alu_sub = (bus.ins == OP_SUB);
        end
      end
      HALT:    w_next = HALT;
      default: w_next = T1;
    endcase
  end

  // Reset must silence strobes immediately, even though T1 would otherwise decode.
  assign w_gated = (w_en && rst_n) ? w_ctrl : '0;

  assign bus.pc_inc    = w_gated.pc_inc;
  assign bus.pc_out    = w_gated.pc_out;
  assign bus.pc_load   = w_gated.pc_load;
  assign bus.mar_in    = w_gated.mar_in;
  assign bus.ram_out   = w_gated.ram_out;
  assign bus.ir_in     = w_gated.ir_in;
  assign bus.ir_out    = w_gated.ir_out;
  assign bus.acc_in    = w_gated.acc_in;
  assign bus.acc_out   = w_gated.acc_out;
  assign bus.breg_in   = w_gated.breg_in;
  assign bus.alu_sub   = w_gated.alu_sub;
  assign bus.alu_out   = w_gated.alu_out;
  assign bus.outreg_in = w_gated.outreg_in;
  assign bus.halted    = (r_state == HALT);
  assign bus.tstate    = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= T1;
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= bus.step;
      if (w_en) begin
        r_state <= w_next;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed-vector bench for ctrl_seq: dut0 runs full six-state cycles, dut1 short-cycles.
module tb_ctrl_seq;
  localparam logic [12:0] PC_INC  = 13'h1000;
  localparam logic [12:0] PC_OUT  = 13'h0800;
  localparam logic [12:0] PC_LOAD = 13'h0400;
  localparam logic [12:0] MAR_IN  = 13'h0200;
  localparam logic [12:0] RAM_OUT = 13'h0100;
  localparam logic [12:0] IR_IN   = 13'h0080;
  localparam logic [12:0] IR_OUT  = 13'h0040;
  localparam logic [12:0] ACC_IN  = 13'h0020;
  localparam logic [12:0] ACC_OUT = 13'h0010;
  localparam logic [12:0] BREG_IN = 13'h0008;
  localparam logic [12:0] ALU_SUB = 13'h0004;
  localparam logic [12:0] ALU_OUT = 13'h0002;
  localparam logic [12:0] OUT_IN  = 13'h0001;
  localparam logic [12:0] NONE    = 13'h0000;
  localparam logic [12:0] F1      = PC_OUT | MAR_IN;
  localparam logic [12:0] F2      = PC_INC;
  localparam logic [12:0] F3      = RAM_OUT | IR_IN;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_seq_if if0();
  ctrl_seq_if if1();

  ctrl_seq #(.SHORT_CYCLE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  ctrl_seq #(.SHORT_CYCLE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  wire [12:0] ctl0 = {if0.pc_inc, if0.pc_out, if0.pc_load, if0.mar_in, if0.ram_out, if0.ir_in,
                      if0.ir_out, if0.acc_in, if0.acc_out, if0.breg_in, if0.alu_sub, if0.alu_out,
                      if0.outreg_in};
  wire [12:0] ctl1 = {if1.pc_inc, if1.pc_out, if1.pc_load, if1.mar_in, if1.ram_out, if1.ir_in,
                      if1.ir_out, if1.acc_in, if1.acc_out, if1.breg_in, if1.alu_sub, if1.alu_out,
                      if1.outreg_in};

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  ins;
    logic        run;
    logic        step;
    logic [12:0] ctrl;
    logic [2:0]  ts;
    logic        hlt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int idx, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] ins, input logic run, input logic step,
                     input logic [12:0] ctrl, input logic [2:0] ts, input logic hlt);
    vec_t v;
    v.ins = ins; v.run = run; v.step = step; v.ctrl = ctrl; v.ts = ts; v.hlt = hlt;
    vq.push_back(v);
  endtask

  task automatic drive(input bit sel, input logic [3:0] ins, input logic run, input logic step);
    if (sel) begin
      if1.ins = ins; if1.run = run; if1.step = step;
    end else begin
      if0.ins = ins; if0.run = run; if0.step = step;
    end
  endtask

  task automatic check_state(input string name, input int idx, input bit sel,
                             input logic [12:0] ctrl, input logic [2:0] ts, input logic hlt);
    chk({name, "_ctrl"}, idx, sel ? ctl1 : ctl0, ctrl);
    chk({name, "_tstate"}, idx, {10'b0, (sel ? if1.tstate : if0.tstate)}, {10'b0, ts});
    chk({name, "_halted"}, idx, {12'b0, (sel ? if1.halted : if0.halted)}, {12'b0, hlt});
  endtask

  // Each row: inputs applied after a rising edge, outputs compared on the falling edge.
  task automatic run_vec(input bit sel, input string name);
    foreach (vq[i]) begin
      drive(sel, vq[i].ins, vq[i].run, vq[i].step);
      @(negedge clk);
      check_state(name, i, sel, vq[i].ctrl, vq[i].ts, vq[i].hlt);
      @(posedge clk);
      #1;
    end
    vq.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if ($countones({if0.ram_out, if0.acc_out, if0.alu_out}) > 1 ||
          $countones({if0.pc_out, if0.ir_out}) > 1 ||
          $countones({if1.ram_out, if1.acc_out, if1.alu_out}) > 1 ||
          $countones({if1.pc_out, if1.ir_out}) > 1) begin
        n_err++;
        $display("FAIL bus_contention: ctl0=%0h ctl1=%0h, expected one driver per bus", ctl0, ctl1);
      end
    end
  end

  initial begin
    drive(0, 4'h0, 1'b1, 1'b0);
    drive(1, 4'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state("reset0", 0, 0, NONE, 3'd0, 1'b0);
    check_state("reset1", 0, 1, NONE, 3'd0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full-length cycles: LDA (fetch with ins=F shows fetch ignores opcode), ADD, SUB, JMP, OUT, NOP.
    add(4'hF, 1, 0, F1, 3'd0, 0); add(4'hF, 1, 0, F2, 3'd1, 0); add(4'hF, 1, 0, F3, 3'd2, 0);
    add(4'h0, 1, 0, IR_OUT | MAR_IN, 3'd3, 0); add(4'h0, 1, 0, RAM_OUT | ACC_IN, 3'd4, 0);
    add(4'h0, 1, 0, NONE, 3'd5, 0);
    add(4'h1, 1, 0, F1, 3'd0, 0); add(4'h1, 1, 0, F2, 3'd1, 0); add(4'h1, 1, 0, F3, 3'd2, 0);
    add(4'h1, 1, 0, IR_OUT | MAR_IN, 3'd3, 0); add(4'h1, 1, 0, RAM_OUT | BREG_IN, 3'd4, 0);
    add(4'h1, 1, 0, ALU_OUT | ACC_IN, 3'd5, 0);
    add(4'h2, 1, 0, F1, 3'd0, 0); add(4'h2, 1, 0, F2, 3'd1, 0); add(4'h2, 1, 0, F3, 3'd2, 0);
    add(4'h2, 1, 0, IR_OUT | MAR_IN, 3'd3, 0); add(4'h2, 1, 0, RAM_OUT | BREG_IN, 3'd4, 0);
    add(4'h2, 1, 0, ALU_OUT | ACC_IN | ALU_SUB, 3'd5, 0);
    add(4'h3, 1, 0, F1, 3'd0, 0); add(4'h3, 1, 0, F2, 3'd1, 0); add(4'h3, 1, 0, F3, 3'd2, 0);
    add(4'h3, 1, 0, IR_OUT | PC_LOAD, 3'd3, 0); add(4'h3, 1, 0, NONE, 3'd4, 0);
    add(4'h3, 1, 0, NONE, 3'd5, 0);
    add(4'hE, 1, 0, F1, 3'd0, 0); add(4'hE, 1, 0, F2, 3'd1, 0); add(4'hE, 1, 0, F3, 3'd2, 0);
    add(4'hE, 1, 0, ACC_OUT | OUT_IN, 3'd3, 0); add(4'hE, 1, 0, NONE, 3'd4, 0);
    add(4'hE, 1, 0, NONE, 3'd5, 0);
    add(4'h7, 1, 0, F1, 3'd0, 0); add(4'h7, 1, 0, F2, 3'd1, 0); add(4'h7, 1, 0, F3, 3'd2, 0);
    add(4'h7, 1, 0, NONE, 3'd3, 0); add(4'h7, 1, 0, NONE, 3'd4, 0); add(4'h7, 1, 0, NONE, 3'd5, 0);
    run_vec(0, "run");

    // Single-step: held step gives one advance; a new rising edge gives another.
    add(4'h7, 0, 0, NONE, 3'd0, 0);
    add(4'h7, 0, 1, F1, 3'd0, 0);
    for (int k = 0; k < 4; k++) add(4'h7, 0, 1, NONE, 3'd1, 0);
    add(4'h7, 0, 0, NONE, 3'd1, 0);
    add(4'h7, 0, 1, F2, 3'd1, 0);
    add(4'h7, 0, 0, NONE, 3'd2, 0);
    add(4'h7, 1, 1, F3, 3'd2, 0);
    add(4'h7, 1, 1, NONE, 3'd3, 0); add(4'h7, 1, 0, NONE, 3'd4, 0); add(4'h7, 1, 0, NONE, 3'd5, 0);
    run_vec(0, "step");

    // HLT: enter HALT, ignore run/step, leave only through asynchronous reset.
    add(4'hF, 1, 0, F1, 3'd0, 0); add(4'hF, 1, 0, F2, 3'd1, 0); add(4'hF, 1, 0, F3, 3'd2, 0);
    add(4'hF, 1, 0, NONE, 3'd3, 0);
    run_vec(0, "hlt");
    for (int k = 0; k < 20; k++) begin
      drive(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      check_state("halt", k, 0, NONE, 3'd7, 1'b1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_state("halt_rst", 0, 0, NONE, 3'd0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset asserted mid-T5 of ADD drops strobes without a clock edge.
    add(4'h1, 1, 0, F1, 3'd0, 0); add(4'h1, 1, 0, F2, 3'd1, 0); add(4'h1, 1, 0, F3, 3'd2, 0);
    add(4'h1, 1, 0, IR_OUT | MAR_IN, 3'd3, 0);
    run_vec(0, "add_pre");
    drive(0, 4'h1, 1'b1, 1'b0);
    @(negedge clk);
    check_state("add_t5", 0, 0, RAM_OUT | BREG_IN, 3'd4, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_state("add_rst", 0, 0, NONE, 3'd0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    add(4'h0, 1, 0, F1, 3'd0, 0); add(4'h0, 1, 0, F2, 3'd1, 0); add(4'h0, 1, 0, F3, 3'd2, 0);
    add(4'h0, 1, 0, IR_OUT | MAR_IN, 3'd3, 0); add(4'h0, 1, 0, RAM_OUT | ACC_IN, 3'd4, 0);
    add(4'h0, 1, 0, NONE, 3'd5, 0); add(4'h0, 1, 0, F1, 3'd0, 0);
    run_vec(0, "post_rst");

    // Short cycle: JMP/NOP/OUT end at T4, LDA at T5, ADD at T6.
    add(4'h3, 1, 0, F1, 3'd0, 0); add(4'h3, 1, 0, F2, 3'd1, 0); add(4'h3, 1, 0, F3, 3'd2, 0);
    add(4'h3, 1, 0, IR_OUT | PC_LOAD, 3'd3, 0);
    add(4'h7, 1, 0, F1, 3'd0, 0); add(4'h7, 1, 0, F2, 3'd1, 0); add(4'h7, 1, 0, F3, 3'd2, 0);
    add(4'h7, 1, 0, NONE, 3'd3, 0);
    add(4'hE, 1, 0, F1, 3'd0, 0); add(4'hE, 1, 0, F2, 3'd1, 0); add(4'hE, 1, 0, F3, 3'd2, 0);
    add(4'hE, 1, 0, ACC_OUT | OUT_IN, 3'd3, 0);
    add(4'h0, 1, 0, F1, 3'd0, 0); add(4'h0, 1, 0, F2, 3'd1, 0); add(4'h0, 1, 0, F3, 3'd2, 0);
    add(4'h0, 1, 0, IR_OUT | MAR_IN, 3'd3, 0); add(4'h0, 1, 0, RAM_OUT | ACC_IN, 3'd4, 0);
    add(4'h1, 1, 0, F1, 3'd0, 0); add(4'h1, 1, 0, F2, 3'd1, 0); add(4'h1, 1, 0, F3, 3'd2, 0);
    add(4'h1, 1, 0, IR_OUT | MAR_IN, 3'd3, 0); add(4'h1, 1, 0, RAM_OUT | BREG_IN, 3'd4, 0);
    add(4'h1, 1, 0, ALU_OUT | ACC_IN, 3'd5, 0);
    add(4'hF, 1, 0, F1, 3'd0, 0); add(4'hF, 1, 0, F2, 3'd1, 0); add(4'hF, 1, 0, F3, 3'd2, 0);
    add(4'hF, 1, 0, NONE, 3'd3, 0); add(4'hF, 1, 0, NONE, 3'd7, 1);
    run_vec(1, "short");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
